// File: rtl/exception_unit.sv
// -----------------------------------------------------------------------------
// exception_unit
//
// Handles the decoder's exception and RTI strobes. An accepted request saves
// the return PC in epc (exception only), sends a held PC-redirect request to
// fetch, and pulses flush for one cycle to squash younger instructions. The
// unit also tracks whether the core is running inside the exception handler.
// If an exception arrives while the handler is already running, the unit
// raises a sticky double_fault and enters a terminal state that only reset
// clears.
//
// Handshake (redirect side): redirect_valid rises on the edge that accepts a
// request. redirect_pc is stable while redirect_valid=1. The transfer completes
// on the first rising edge that sees redirect_valid=1 and redirect_ack=1, and
// redirect_valid is 0 after that edge. redirect_ack has no effect while
// redirect_valid=0. In FAULT the redirect is never released, so fetch keeps
// spinning at the handler address.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid, stall  decode holds an instruction / decode is stalled
//   exception, rti    decoder strobes; exception wins when both are high
//   pc_next           PC+2 of the requesting instruction
//   redirect_ack      fetch accepted the redirect this cycle
//   redirect_valid    redirect request pending
//   redirect_pc       redirect target
//   flush             one-cycle squash pulse
//   epc               saved return PC
//   in_handler        core is executing the handler
//   double_fault      sticky: exception raised while in_handler
//   exc_count         accepted exceptions, saturating
//   fsm_state         FSM state for observation (0 IDLE, 1 REDIRECT, 2 FAULT)
// -----------------------------------------------------------------------------
module exception_unit #(
    parameter logic [15:0] HANDLER_ADDR = 16'h0002,
    parameter int          CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             stall,
    input  logic             exception,
    input  logic             rti,
    input  logic [15:0]      pc_next,
    input  logic             redirect_ack,
    output logic             redirect_valid,
    output logic [15:0]      redirect_pc,
    output logic             flush,
    output logic [15:0]      epc,
    output logic             in_handler,
    output logic             double_fault,
    output logic [CNT_W-1:0] exc_count,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             redirect_valid_d;
    logic [15:0]      redirect_pc_d;
    logic             flush_d;
    logic [15:0]      epc_d;
    logic             in_handler_d;
    logic             double_fault_d;
    logic [CNT_W-1:0] exc_count_d;

    logic sample;
    logic take_fault;
    logic take_exc;
    logic take_rti;

    // Nothing is sampled while decode is stalled.
    assign sample = req_valid & ~stall;

    // A nested exception is honoured in REDIRECT as well as IDLE: decode is
    // being flushed, but a fault inside the handler must never be lost.
    assign take_fault = sample & exception & in_handler & (state_q != FAULT);
    assign take_exc   = sample & exception & ~in_handler & (state_q == IDLE);
    assign take_rti   = sample & rti & ~exception & (state_q == IDLE);

    always_comb begin
        state_d          = state_q;
        redirect_valid_d = redirect_valid;
        redirect_pc_d    = redirect_pc;
        flush_d          = 1'b0;
        epc_d            = epc;
        in_handler_d     = in_handler;
        double_fault_d   = double_fault;
        exc_count_d      = exc_count;

        if (take_fault) begin
            // epc and exc_count stay untouched so the first fault's context
            // survives for post-mortem.
            state_d          = FAULT;
            double_fault_d   = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = HANDLER_ADDR;
            flush_d          = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_exc) begin
                        state_d          = REDIRECT;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = HANDLER_ADDR;
                        flush_d          = 1'b1;
                        epc_d            = pc_next;
                        in_handler_d     = 1'b1;
                        if (exc_count != {CNT_W{1'b1}}) begin
                            exc_count_d = exc_count + CNT_W'(1);
                        end
                    end else if (take_rti) begin
                        // Honoured even outside the handler: returns to
                        // whatever epc currently holds.
                        state_d          = REDIRECT;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = epc;
                        flush_d          = 1'b1;
                        in_handler_d     = 1'b0;
                    end
                end
                REDIRECT: begin
                    if (redirect_ack) begin
                        state_d          = IDLE;
                        redirect_valid_d = 1'b0;
                    end
                end
                FAULT: begin
                    // Terminal: the redirect stays asserted until reset.
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= 16'h0000;
            flush          <= 1'b0;
            epc            <= 16'h0000;
            in_handler     <= 1'b0;
            double_fault   <= 1'b0;
            exc_count      <= '0;
        end else begin
            state_q        <= state_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
            flush          <= flush_d;
            epc            <= epc_d;
            in_handler     <= in_handler_d;
            double_fault   <= double_fault_d;
            exc_count      <= exc_count_d;
        end
    end

    assign fsm_state = state_q;

endmodule

// File: doc/exception_unit.md
# exception_unit

Sequential responder for the `exception` and `RTI` strobes produced by the instruction decoder. It accepts one request per decoded instruction and captures the return PC into EPC. It issues a held PC-redirect request plus a one-cycle pipeline flush to fetch, and tracks whether the core is executing inside the exception handler. It sits between decode (request side) and the fetch PC mux (redirect side).

## Interface
Parameters:
- HANDLER_ADDR, 16'h0002: PC loaded on exception entry.
- CNT_W, 8: width of the saturating exception counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  decode holds a valid instruction this cycle.
- stall  in  1  decode stalled; requests are not sampled while high.
- exception  in  1  decoder exception strobe (SIIC or illegal opcode).
- rti  in  1  decoder RTI strobe.
- pc_next  in  16  PC+2 of the requesting instruction.
- redirect_ack  in  1  fetch accepted the redirect this cycle.
- redirect_valid  out  1  redirect request pending.
- redirect_pc  out  16  target PC; stable while redirect_valid=1.
- flush  out  1  one-cycle pulse that squashes younger instructions.
- epc  out  16  saved return PC.
- in_handler  out  1  core is executing the handler.
- double_fault  out  1  sticky flag: exception raised while in_handler.
- exc_count  out  CNT_W  accepted exceptions, saturating.

## Operation
- A request is accepted when req_valid & ~stall & (exception | rti) & state==IDLE.
- FSM states:
  - IDLE to REDIRECT on any accepted request.
  - REDIRECT to IDLE on redirect_ack.
  - IDLE or REDIRECT to FAULT on an accepted exception while in_handler=1.
  - FAULT is terminal until reset.
- Exception accepted:
  - epc <= pc_next.
  - redirect_pc <= HANDLER_ADDR.
  - in_handler <= 1.
  - exc_count <= exc_count+1, saturating at all-ones.
- RTI accepted:
  - redirect_pc <= epc.
  - in_handler <= 0.
  - epc unchanged.
  - RTI with in_handler=0 is still honoured and redirects to the current epc (0 after reset).
- exception and rti both high: exception wins; rti is ignored.
- Exception while in_handler=1:
  - double_fault <= 1, state <= FAULT.
  - redirect_pc <= HANDLER_ADDR.
  - One flush pulse is issued.
  - redirect_valid stays high until reset. Fetch then spins at the handler, and the top level treats double_fault as halt.
  - epc and exc_count are not updated.
- Requests arriving in REDIRECT or FAULT are ignored, because decode is flushed. Exception: a new exception in REDIRECT while in_handler=1 still enters FAULT.
- exc_count never wraps.

## Timing
- Reset (async, rst_n=0), all outputs forced immediately:
  - redirect_valid=0, redirect_pc=0, flush=0.
  - epc=0, in_handler=0, double_fault=0, exc_count=0, state IDLE.
- Request sampled at edge N:
  - From edge N: redirect_valid=1, flush=1, updated epc, redirect_pc and in_handler visible.
  - At edge N+1: flush=0.
- redirect_valid and redirect_pc are held until the edge on which redirect_ack=1. redirect_valid is 0 after that edge.
- redirect_ack sampled on the same cycle flush is high: redirect completes in 1 cycle; IDLE from edge N+1.
- redirect_ack with redirect_valid=0 has no effect.
- Back-to-back: a new request can be accepted on the edge after returning to IDLE. Minimum spacing is 2 cycles.
- stall=1 on a cycle masks sampling entirely. The request is taken on the first unstalled cycle.
- rst_n asserted mid-redirect: pending redirect dropped, epc lost, everything returns to reset values.

## Test plan
- Reset then SIIC:
  - Stimulus: pc_next=16'h0040, exception=1, ack one cycle later.
  - Required: flush pulses 1 cycle, redirect_pc=16'h0002 held 2 cycles, epc=16'h0040, in_handler=1, exc_count=1.
- RTI return:
  - Stimulus: after the SIIC above, rti=1.
  - Required: redirect_pc=16'h0040, in_handler=0, epc unchanged, exc_count unchanged.
- Nested exception:
  - Stimulus: exception while in_handler=1.
  - Required: double_fault=1, redirect_valid stays 1 through redirect_ack, epc stays 16'h0040.
- Stall and simultaneous strobes:
  - Stimulus: exception+rti with stall=1 for 3 cycles, then stall=0.
  - Required: nothing happens during the stall; exception is taken one edge after stall drops; rti ignored.
- Ignored and saturation:
  - Stimulus: a second exception while in REDIRECT with in_handler=0. Separately, 256 exception/RTI pairs with CNT_W=8.
  - Required: the second exception is ignored; exc_count holds at 8'hFF.
- Async reset mid-redirect:
  - Stimulus: drop rst_n while redirect_valid=1.
  - Required: all outputs are 0 before the next clk edge.
